// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared types and clause word field helpers for the BCP clause scanner
package bcp_pkg;

  localparam int MAX_VARS  = 32;
  localparam int MAX_VAR_W = 8;

  typedef logic [MAX_VARS-1:0]   var_vec_t;
  typedef logic [2*MAX_VARS-1:0] word_vec_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_e;

  typedef enum logic [2:0] {EMPTY_SLOT, SAT, CONFLICT, UNIT, OPEN} clause_class_e;

  typedef struct packed {
    clause_class_e          cls;
    logic [MAX_VAR_W-1:0]   var_idx;
    logic                   val;
  } clause_eval_t;

  // Mask of the low n variable positions.
  function automatic var_vec_t low_mask(input int n);
    var_vec_t m;
    m = '0;
    for (int i = 0; i < MAX_VARS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Presence mask sits directly above the polarity field.
  function automatic var_vec_t clause_presence(input word_vec_t word, input int n);
    return var_vec_t'(word >> n) & low_mask(n);
  endfunction

  // Polarity field occupies the low n bits; 1 means a positive literal.
  function automatic var_vec_t clause_polarity(input word_vec_t word, input int n);
    return var_vec_t'(word) & low_mask(n);
  endfunction

endpackage

// File: rtl/bcp_clause_scanner_if.sv
// rtl/bcp_clause_scanner_if.sv - clause store read port between scanner and store
interface bcp_clause_scanner_if #(
  parameter int VAR_NUM = 9,
  parameter int ADDR_W  = 3
);
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_en;
  logic                 mem_write;
  logic [2*VAR_NUM-1:0] mem_rdata;

  modport master (output mem_addr, output mem_en, output mem_write, input mem_rdata);
  modport slave  (input mem_addr, input mem_en, input mem_write, output mem_rdata);
endinterface

// File: rtl/bcp_clause_eval.sv
// rtl/bcp_clause_eval.sv - combinational classification of one clause word against an assignment
module bcp_clause_eval
  import bcp_pkg::*;
#(
  parameter int VAR_NUM = 9
) (
  input  logic [2*VAR_NUM-1:0] word,
  input  logic [VAR_NUM-1:0]   asg_valid,
  input  logic [VAR_NUM-1:0]   asg_value,
  output clause_eval_t         result
);

  logic [VAR_NUM-1:0]   pres;
  logic [VAR_NUM-1:0]   pol;
  logic [VAR_NUM-1:0]   is_true;
  logic [VAR_NUM-1:0]   is_free;
  logic                 seen_free;
  logic                 multi_free;
  logic [MAX_VAR_W-1:0] low_idx;
  logic                 low_pol;

  assign pres    = VAR_NUM'(clause_presence(word_vec_t'(word), VAR_NUM));
  assign pol     = VAR_NUM'(clause_polarity(word_vec_t'(word), VAR_NUM));
  assign is_true = pres & asg_valid & ~(asg_value ^ pol);
  assign is_free = pres & ~asg_valid;

  // Find the lowest free literal and whether more than one is free, then classify.
  always_comb begin
    seen_free  = 1'b0;
    multi_free = 1'b0;
    low_idx    = '0;
    low_pol    = 1'b0;
    for (int i = 0; i < VAR_NUM; i++) begin
      if (is_free[i]) begin
        if (seen_free) begin
          multi_free = 1'b1;
        end else begin
          low_idx = MAX_VAR_W'(i);
          low_pol = pol[i];
        end
        seen_free = 1'b1;
      end
    end

    result.cls     = OPEN;
    result.var_idx = low_idx;
    result.val     = low_pol;
    if (pres == '0)         result.cls = EMPTY_SLOT;
    else if (|is_true)      result.cls = SAT;
    else if (!seen_free)    result.cls = CONFLICT;
    else if (!multi_free)   result.cls = UNIT;
    else                    result.cls = OPEN;
  end

endmodule

// File: rtl/bcp_clause_scanner.sv
// rtl/bcp_clause_scanner.sv - BCP clause store read sequencer; BCP_SAT_COUNT_EN adds a satisfied-clause counter
module bcp_clause_scanner
  import bcp_pkg::*;
#(
  parameter int VAR_NUM    = 9,
  parameter int CLAUSE_NUM = 7,
  localparam int ADDR_W    = $clog2(CLAUSE_NUM),
  localparam int VAR_W     = $clog2(VAR_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VAR_NUM-1:0]   asg_valid,
  input  logic [VAR_NUM-1:0]   asg_value,
  bcp_clause_scanner_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 conflict,
  output logic [ADDR_W-1:0]    conflict_idx,
  output logic                 unit_found,
  output logic [VAR_W-1:0]     unit_var,
  output logic                 unit_val,
  output logic [ADDR_W:0]      sat_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLAUSE_NUM - 1);

  scan_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                 rvalid_q, rvalid_d;
  logic [VAR_NUM-1:0]   snap_valid_q, snap_valid_d;
  logic [VAR_NUM-1:0]   snap_value_q, snap_value_d;
  logic                 conflict_q, conflict_d;
  logic [ADDR_W-1:0]    conflict_idx_q, conflict_idx_d;
  logic                 unit_found_q, unit_found_d;
  logic [VAR_W-1:0]     unit_var_q, unit_var_d;
  logic                 unit_val_q, unit_val_d;
  logic                 issue;
  logic                 accept;
  logic                 hit_conflict;
  clause_eval_t         ev;

  bcp_clause_eval #(.VAR_NUM(VAR_NUM)) u_eval (
    .word      (mem.mem_rdata),
    .asg_valid (snap_valid_q),
    .asg_value (snap_value_q),
    .result    (ev)
  );

  // A start is taken whenever no scan is running, including the DONE cycle.
  assign accept       = start && (state_q == IDLE || state_q == DONE);
  // Conflict on the word arriving now stops further reads in this very cycle.
  assign hit_conflict = rvalid_q && (ev.cls == CONFLICT);

  assign mem.mem_addr  = addr_q;
  assign mem.mem_en    = issue;
  assign mem.mem_write = 1'b0;

  assign busy         = (state_q == SCAN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign conflict     = conflict_q;
  assign conflict_idx = conflict_idx_q;
  assign unit_found   = unit_found_q;
  assign unit_var     = unit_var_q;
  assign unit_val     = unit_val_q;

  // Next-state, read issue and result capture.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rd_addr_d      = rd_addr_q;
    issue          = 1'b0;
    snap_valid_d   = snap_valid_q;
    snap_value_d   = snap_value_q;
    conflict_d     = conflict_q;
    conflict_idx_d = conflict_idx_q;
    unit_found_d   = unit_found_q;
    unit_var_d     = unit_var_q;
    unit_val_d     = unit_val_q;

    case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: begin
        issue = !hit_conflict;
        if (hit_conflict)             state_d = DONE;
        else if (addr_q == LAST_ADDR) state_d = DRAIN;
        else                          addr_d  = addr_q + 1'b1;
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = accept ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      snap_valid_d   = asg_valid;
      snap_value_d   = asg_value;
      addr_d         = '0;
      conflict_d     = 1'b0;
      conflict_idx_d = '0;
      unit_found_d   = 1'b0;
      unit_var_d     = '0;
      unit_val_d     = 1'b0;
    end

    rvalid_d = issue;
    if (issue) rd_addr_d = addr_q;

    if (rvalid_q) begin
      if (ev.cls == CONFLICT && !conflict_q) begin
        conflict_d     = 1'b1;
        conflict_idx_d = rd_addr_q;
      end else if (ev.cls == UNIT && !unit_found_q) begin
        unit_found_d = 1'b1;
        unit_var_d   = VAR_W'(ev.var_idx);
        unit_val_d   = ev.val;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      rd_addr_q      <= '0;
      rvalid_q       <= 1'b0;
      snap_valid_q   <= '0;
      snap_value_q   <= '0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      unit_found_q   <= 1'b0;
      unit_var_q     <= '0;
      unit_val_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rd_addr_q      <= rd_addr_d;
      rvalid_q       <= rvalid_d;
      snap_valid_q   <= snap_valid_d;
      snap_value_q   <= snap_value_d;
      conflict_q     <= conflict_d;
      conflict_idx_q <= conflict_idx_d;
      unit_found_q   <= unit_found_d;
      unit_var_q     <= unit_var_d;
      unit_val_q     <= unit_val_d;
    end
  end

`ifdef BCP_SAT_COUNT_EN
  logic [ADDR_W:0] sat_count_q, sat_count_d;

  // Count satisfied clauses of the current scan.
  always_comb begin
    sat_count_d = sat_count_q;
    if (accept)                          sat_count_d = '0;
    else if (rvalid_q && ev.cls == SAT)  sat_count_d = sat_count_q + 1'b1;
  end

  // Satisfied-clause counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// tb/tb_bcp_clause_scanner.sv - directed self-checking bench for bcp_clause_scanner
module tb_bcp_clause_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] asg_valid;
  logic [8:0] asg_value;
  logic       busy, done, conflict, unit_found, unit_val;
  logic [2:0] conflict_idx;
  logic [3:0] unit_var;
  logic [3:0] sat_count;

  logic [17:0] store [0:6];
  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc, en_cyc, done_cnt, busy_cnt;
  int exp_sat;

  bcp_clause_scanner_if #(.VAR_NUM(9), .ADDR_W(3)) mem_if ();

  bcp_clause_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .asg_valid    (asg_valid),
    .asg_value    (asg_value),
    .mem          (mem_if),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .conflict_idx (conflict_idx),
    .unit_found   (unit_found),
    .unit_var     (unit_var),
    .unit_val     (unit_val),
    .sat_count    (sat_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_if.mem_en && mem_if.mem_addr < 3'd7) mem_if.mem_rdata <= store[mem_if.mem_addr];
    else                                          mem_if.mem_rdata <= 'x;
  end

  function automatic logic [17:0] cw(input logic [8:0] pres, input logic [8:0] pol);
    return {pres, pol};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_store();
    for (int i = 0; i < 7; i++) store[i] = '0;
  endtask

  task automatic run_scan(input int toggle_at, output int n, output int en);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n  = 0;
    en = 0;
    while (!done && n < 40) begin
      if (n == toggle_at) asg_value = ~asg_value;
      if (mem_if.mem_en) en++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    asg_valid = '0;
    asg_value = '0;
    clear_store();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_if.mem_en, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_unit", unit_found, 0);
    chk("rst_sat", sat_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: {A|B},{-B|-C},{D|E}, nothing assigned
    store[0] = cw(9'b000000011, 9'b000000011);
    store[1] = cw(9'b000000110, 9'b000000000);
    store[2] = cw(9'b000011000, 9'b000011000);
    run_scan(-1, cyc, en_cyc);
    chk("t1_done_cycle", cyc, 8);
    chk("t1_mem_en_cycles", en_cyc, 7);
    chk("t1_conflict", conflict, 0);
    chk("t1_unit", unit_found, 0);
    chk("t1_mem_write", mem_if.mem_write, 0);

    // 2: A=0 makes slot 0 a unit clause on B=1
    asg_valid = 9'b000000001;
    asg_value = 9'b000000000;
    run_scan(-1, cyc, en_cyc);
    chk("t2_done_cycle", cyc, 8);
    chk("t2_unit", unit_found, 1);
    chk("t2_unit_var", unit_var, 1);
    chk("t2_unit_val", unit_val, 1);
    chk("t2_conflict", conflict, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_done_single_pulse", done, 0);
    chk("t2_unit_hold", unit_found, 1);

    // 3: A=0,B=0 makes slot 0 conflict
    asg_valid = 9'b000000011;
    asg_value = 9'b000000000;
    run_scan(-1, cyc, en_cyc);
    chk("t3_done_cycle", cyc, 2);
    chk("t3_mem_en_cycles", en_cyc, 1);
    chk("t3_conflict", conflict, 1);
    chk("t3_conflict_idx", conflict_idx, 0);

    // 4: units at slots 2 and 5 with A=1; assignment flips mid-scan
    clear_store();
    store[2] = cw(9'b000000101, 9'b000000100);
    store[5] = cw(9'b000001001, 9'b000000000);
    asg_valid = 9'b000000001;
    asg_value = 9'b000000001;
    run_scan(2, cyc, en_cyc);
    chk("t4_done_cycle", cyc, 8);
    chk("t4_unit", unit_found, 1);
    chk("t4_unit_var", unit_var, 2);
    chk("t4_unit_val", unit_val, 1);
    chk("t4_conflict", conflict, 0);

    // 7: unit at slot 1, conflict on the last slot
    clear_store();
    store[1] = cw(9'b000000101, 9'b000000100);
    store[6] = cw(9'b000000001, 9'b000000000);
    asg_valid = 9'b000000001;
    asg_value = 9'b000000001;
    run_scan(-1, cyc, en_cyc);
    chk("t7_done_cycle", cyc, 8);
    chk("t7_mem_en_cycles", en_cyc, 7);
    chk("t7_conflict", conflict, 1);
    chk("t7_conflict_idx", conflict_idx, 6);
    chk("t7_unit", unit_found, 1);
    chk("t7_unit_var", unit_var, 2);

    // 6: all variables 1, positive-only clauses in slots 0..3
    clear_store();
    store[0] = cw(9'b000000001, 9'b000000001);
    store[1] = cw(9'b000000110, 9'b000000110);
    store[2] = cw(9'b000001000, 9'b000001000);
    store[3] = cw(9'b001110000, 9'b001110000);
    asg_valid = 9'h1FF;
    asg_value = 9'h1FF;
`ifdef BCP_SAT_COUNT_EN
    exp_sat = 4;
`else
    exp_sat = 0;
`endif
    run_scan(-1, cyc, en_cyc);
    chk("t6_done_cycle", cyc, 8);
    chk("t6_sat_count", sat_count, exp_sat);
    chk("t6_conflict", conflict, 0);
    chk("t6_unit", unit_found, 0);

    // 5: start during busy ignored, reset mid-scan
    store[0] = cw(9'b000000011, 9'b000000011);
    asg_valid = 9'b000000001;
    asg_value = 9'b000000000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t5_busy", busy, 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_unit_before_rst", unit_found, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_mem_en", mem_if.mem_en, 0);
    chk("t5_rst_unit", unit_found, 0);
    chk("t5_rst_conflict", conflict, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_sat", sat_count, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_second_scan", busy_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
